// File: rtl/speaker_pcm.sv
// Turns the ucom43 1-bit speaker line into 16-bit unsigned PCM for the audio mixer.
// The chain is: synchroniser, per-sample up/down window, fractional strobe, one-pole IIR, and idle fade.
// state  | meaning
// S_IDLE | no recent speaker activity; window value forced to 0 so output fades to midpoint
// S_RUN  | speaker toggling; idle_cnt counts strobes since the last window with an edge
module speaker_pcm #(
  parameter int CLK_HZ       = 20000000,
  parameter int SAMPLE_HZ    = 48000,
  parameter int AMPL         = 16383,
  parameter int GAIN_SHL     = 6,
  parameter int SHIFT        = 4,
  parameter int IDLE_SAMPLES = 4800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spk,
  input  logic        mute,
  output logic [15:0] audio_out,
  output logic        sample_strobe,
  output logic        active
);

  localparam int ACC_W  = $clog2(CLK_HZ) + 1;
  localparam int IDLE_W = $clog2(IDLE_SAMPLES + 1);
  localparam logic [ACC_W-1:0]   SAMPLE_INC = ACC_W'(SAMPLE_HZ);
  localparam logic [ACC_W-1:0]   CLK_MOD    = ACC_W'(CLK_HZ);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_SAMPLES - 1);
  localparam logic signed [31:0] AMPL_W     = 32'(AMPL);
  localparam logic signed [17:0] X_MAX      = 18'(AMPL);
  localparam logic signed [17:0] D_LIM      = 18'sd1 <<< SHIFT;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state, state_nxt;
  logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
  logic                s1, s2, s3;
  logic                spk_edge, edge_seen;
  logic [ACC_W-1:0]    acc, acc_sum, acc_nxt;
  logic                strb;
  logic signed [11:0]  w, w_closed;
  logic signed [31:0]  w_ext, w_gain;
  logic signed [17:0]  x, y, d, y_nxt;
  logic [15:0]         ys, pcm_nxt;

  // acc never exceeds CLK_HZ + SAMPLE_HZ, which fits in ACC_W bits
  always_comb begin
    acc_sum = acc + SAMPLE_INC;
    strb    = (acc_sum >= CLK_MOD);
    acc_nxt = strb ? (acc_sum - CLK_MOD) : acc_sum;
  end

  always_comb begin
    spk_edge = s2 ^ s3;
    w_closed = w + (s2 ? 12'sd1 : -12'sd1);
    w_ext    = {{20{w_closed[11]}}, w_closed};
    w_gain   = w_ext <<< GAIN_SHL;
    if (w_gain > AMPL_W)       x = X_MAX;
    else if (w_gain < -AMPL_W) x = -X_MAX;
    else                       x = w_gain[17:0];
    if (state == S_IDLE) x = 18'sd0;
    d = x - y;
    // the +/-1 tail lets y land exactly on x instead of stalling within 2^SHIFT of it
    if ((d >= D_LIM) || (d <= -D_LIM)) y_nxt = y + (d >>> SHIFT);
    else if (d > 18'sd0)               y_nxt = y + 18'sd1;
    else if (d < 18'sd0)               y_nxt = y - 18'sd1;
    else                               y_nxt = y;
    if (y_nxt > 18'sd32767)       ys = 16'h7FFF;
    else if (y_nxt < -18'sd32768) ys = 16'h8000;
    else                          ys = y_nxt[15:0];
    pcm_nxt = {~ys[15], ys[14:0]};
  end

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    active    = (state == S_RUN);
    case (state)
      S_IDLE: begin
        if (spk_edge) begin
          state_nxt = S_RUN;
          idle_nxt  = '0;
        end
      end
      S_RUN: begin
        if (strb) begin
          if (spk_edge || edge_seen) begin
            idle_nxt = '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state_nxt = S_IDLE;
            idle_nxt  = '0;
          end else begin
            idle_nxt = idle_cnt + IDLE_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      acc           <= '0;
      w             <= '0;
      y             <= '0;
      edge_seen     <= 1'b0;
      sample_strobe <= 1'b0;
      audio_out     <= 16'h8000;
    end else begin
      s1            <= spk;
      s2            <= s1;
      s3            <= s2;
      acc           <= acc_nxt;
      sample_strobe <= strb;
      if (strb) begin
        w         <= '0;
        y         <= y_nxt;
        edge_seen <= 1'b0;
        audio_out <= mute ? 16'h8000 : pcm_nxt;
      end else begin
        w <= w_closed;
        if (spk_edge) edge_seen <= 1'b1;
      end
    end
  end

endmodule
